// File: rtl/mul_hilo_ctrl_if.sv
// Request, multiplier and HI/LO read bundle for mul_hilo_ctrl.
// Latency: none (wires only).
// Backpressure: req_ready and rd_stall are driven by the controller (slave side).
//
// Signals:
//   req_valid/req_ready/req_op/req_a/req_b : operation request handshake
//   mul_a/mul_b -> external signed multiplier, mul_c <- its registered 64-bit product
//   hi/lo/busy/done                         : architectural state and status
//   rd_req/rd_stall                         : consumer read interlock
interface mul_hilo_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_c;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        rd_req;
    logic        rd_stall;

    // Controller side
    modport slave (
        input  req_valid, req_op, req_a, req_b, mul_c, rd_req,
        output req_ready, mul_a, mul_b, hi, lo, busy, done, rd_stall
    );

    // Requester / multiplier / consumer side
    modport master (
        output req_valid, req_op, req_a, req_b, mul_c, rd_req,
        input  req_ready, mul_a, mul_b, hi, lo, busy, done, rd_stall
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// HI/LO multiply controller: sequences an external signed multiplier and owns HI/LO.
// Latency: multiply accepted at T captures into HI/LO at T+2, done pulses after; MTHI/MTLO take one edge.
// Backpressure: req_ready low in MUL and CAP; rd_stall = rd_req && busy.
//
// Ports: clk, rst_n (async active-low), bus (mul_hilo_ctrl_if.slave).
// Build option: define MUL_UNSIGNED_EN to give MULTU a true unsigned result;
// without it MULTU behaves exactly like MULT.
module mul_hilo_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    mul_hilo_ctrl_if.slave    bus
);

    localparam logic [1:0] OP_MTHI = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_CAP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_acc;
    logic        w_acc_mul;
    logic        w_acc_wr;
    logic        w_busy;
    logic [63:0] w_prod;

    assign w_acc     = bus.req_valid && (r_state == S_IDLE);
    assign w_acc_mul = w_acc && !bus.req_op[1];
    assign w_acc_wr  = w_acc &&  bus.req_op[1];
    assign w_busy    = (r_state != S_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc_mul) w_next = S_MUL;
            S_MUL:   w_next = S_CAP;   // multiplier samples mul_a/mul_b on this edge
            S_CAP:   w_next = S_IDLE;  // mul_c is valid now; HI/LO capture on this edge
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- product correction ----------------
`ifdef MUL_UNSIGNED_EN
    logic        r_op_u;
    logic [63:0] w_corr_a;
    logic [63:0] w_corr_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_u <= 1'b0;
        end else if (w_acc_mul) begin
            r_op_u <= bus.req_op[0];
        end
    end

    // Signed product of the raw bit patterns differs from the unsigned one by
    // 2^32*b when a's top bit is set, and 2^32*a when b's top bit is set.
    assign w_corr_a = (r_op_u && r_mul_a[31]) ? {r_mul_b, 32'h0} : 64'h0;
    assign w_corr_b = (r_op_u && r_mul_b[31]) ? {r_mul_a, 32'h0} : 64'h0;
    assign w_prod   = bus.mul_c + w_corr_a + w_corr_b;
`else
    assign w_prod   = bus.mul_c;
`endif

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a <= 32'h0;
            r_mul_b <= 32'h0;
            r_hi    <= 32'h0;
            r_lo    <= 32'h0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_CAP);
            // Operands stay put until the next accepted multiply.
            if (w_acc_mul) begin
                r_mul_a <= bus.req_a;
                r_mul_b <= bus.req_b;
            end
            // Capture and register writes are exclusive: writes only accept in IDLE.
            if (r_state == S_CAP) begin
                {r_hi, r_lo} <= w_prod;
            end else if (w_acc_wr) begin
                if (bus.req_op == OP_MTHI) r_hi <= bus.req_a;
                else                       r_lo <= bus.req_a;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.rd_stall  = bus.rd_req && w_busy;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed-vector bench for mul_hilo_ctrl with a registered signed multiplier model
// and a scoreboard: stimulus pushes expected {hi,lo}; the monitor pops on done or on
// an accepted MTHI/MTLO.
module tb_mul_hilo_ctrl;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    logic clk = 1'b0;
    logic rst_n;

    mul_hilo_ctrl_if ifc ();

    mul_hilo_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Downstream multiplier: registers the signed product one edge after sampling.
    always @(posedge clk) begin
        ifc.mul_c <= $signed({{32{ifc.mul_a[31]}}, ifc.mul_a}) *
                     $signed({{32{ifc.mul_b[31]}}, ifc.mul_b});
    end

    typedef struct {
        string       nm;
        logic [63:0] v;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'h0;
    logic [31:0] m_lo  = 32'h0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares HI/LO whenever done pulses or an MTHI/MTLO was accepted.
    initial begin : monitor
        bit   pend_mt;
        exp_t e;
        pend_mt = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (ifc.done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no done", ifc.hi, ifc.lo);
                end else begin
                    e = sb_q.pop_front();
                    check(e.nm, {ifc.hi, ifc.lo}, e.v);
                end
            end
            if (pend_mt) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write: got write with no expectation, expected none");
                end else begin
                    e = sb_q.pop_front();
                    check(e.nm, {ifc.hi, ifc.lo}, e.v);
                end
            end
            pend_mt = rst_n && ifc.req_valid && ifc.req_ready && ifc.req_op[1];
        end
    end

    // Drives one request starting now (caller is at/just after a falling edge) and
    // returns at the falling edge following acceptance.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [63:0] expv, input string nm,
                        output int waited, output time t_acc);
        exp_t e;
        waited = 0;
        t_acc  = 0;
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_a     = a;
        ifc.req_b     = b;
        if (push) begin
            e.nm = nm;
            case (op)
                OP_MTHI: e.v = {a, m_lo};
                OP_MTLO: e.v = {m_hi, a};
                default: e.v = expv;
            endcase
            {m_hi, m_lo} = e.v;
            sb_q.push_back(e);
        end
        while (ifc.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            n_vec++; n_err++;
            $display("FAIL %s_accept_timeout: got req_ready=0 for %0d cycles, expected acceptance", nm, waited);
            ifc.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
            ifc.req_valid = 1'b0;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          w;
        time         t0, t1;
        logic [63:0] exp_mu1, exp_mu2, old_hl;

`ifdef MUL_UNSIGNED_EN
        exp_mu1 = 64'h00000001_FFFFFFFE;
        exp_mu2 = 64'hFFFFFFFE_00000001;
`else
        exp_mu1 = 64'hFFFFFFFF_FFFFFFFE;
        exp_mu2 = 64'h00000000_00000001;
`endif

        rst_n         = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'b00;
        ifc.req_a     = 32'h0;
        ifc.req_b     = 32'h0;
        ifc.rd_req    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hilo",    {ifc.hi, ifc.lo},       64'h0);
        check("rst_mulab",   {ifc.mul_a, ifc.mul_b}, 64'h0);
        check("rst_busy",    ifc.busy,               1'b0);
        check("rst_done",    ifc.done,               1'b0);
        check("rst_ready",   ifc.req_ready,          1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT 3 x -2, accepted on the first edge after reset release.
        send(OP_MULT, 32'h3, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFF_FFFFFFFA, "mult_3xm2", w, t0);
        check("first_edge_accept", w, 0);
        #1;
        check("mul_busy",  ifc.busy,               1'b1);
        check("mul_ready", ifc.req_ready,          1'b0);
        check("mul_old_hilo", {ifc.hi, ifc.lo},    64'h0);
        check("mul_operands", {ifc.mul_a, ifc.mul_b}, 64'h00000003_FFFFFFFE);
        @(negedge clk); #1;
        check("cap_busy",  ifc.busy,               1'b1);
        check("cap_old_hilo", {ifc.hi, ifc.lo},    64'h0);
        @(negedge clk); #1;
        check("idle_busy", ifc.busy,               1'b0);
        check("idle_done", ifc.done,               1'b1);

        // Back-to-back multiplies: one accepted every 3 cycles.
        send(OP_MULTU, 32'hFFFFFFFF, 32'h2, 1'b1, exp_mu1, "multu_m1x2", w, t0);
        send(OP_MULT,  32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "mult_min_sq", w, t1);
        check("b2b_spacing", 64'(t1 - t0), 64'd30);
        send(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, exp_mu2, "multu_max_sq", w, t0);
        send(OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF_00000001, "mult_max_sq", w, t0);
        repeat (3) @(negedge clk);

        // Register writes: single cycle, no busy, no done.
        send(OP_MTLO, 32'hCAFEBABE, 32'hDEADDEAD, 1'b1, 64'h0, "mtlo", w, t0);
        #1;
        check("mtlo_busy", ifc.busy, 1'b0);
        check("mtlo_done", ifc.done, 1'b0);
        send(OP_MTHI, 32'h0BADF00D, 32'h0, 1'b1, 64'h0, "mthi", w, t0);
        ifc.rd_req = 1'b1;
        #1;
        check("rd_stall_idle", ifc.rd_stall, 1'b0);
        ifc.rd_req = 1'b0;
        @(negedge clk);

        // MTHI held during an in-flight multiply.
        old_hl = {m_hi, m_lo};
        send(OP_MULT, 32'h10, 32'h10, 1'b1, 64'h00000000_00000100, "mult_16x16", w, t0);
        ifc.req_valid = 1'b1;
        ifc.req_op    = OP_MTHI;
        ifc.req_a     = 32'h12345678;
        ifc.rd_req    = 1'b1;
        #1;
        check("hold_mul_ready", ifc.req_ready,     1'b0);
        check("hold_mul_stall", ifc.rd_stall,      1'b1);
        check("hold_mul_hilo",  {ifc.hi, ifc.lo},  old_hl);
        @(negedge clk); #1;
        check("hold_cap_ready", ifc.req_ready,     1'b0);
        check("hold_cap_stall", ifc.rd_stall,      1'b1);
        ifc.rd_req = 1'b0;
        send(OP_MTHI, 32'h12345678, 32'h0, 1'b1, 64'h0, "mthi_after_mul", w, t0);
        check("mthi_stall_cycles", w, 1);
        repeat (2) @(negedge clk);

        // Reset while a multiply is in MUL: product discarded, no done later.
        send(OP_MULT, 32'h9, 32'h9, 1'b0, 64'h0, "mult_flushed", w, t0);
        rst_n = 1'b0;
        #1;
        check("midrst_hilo", {ifc.hi, ifc.lo}, 64'h0);
        check("midrst_busy", ifc.busy,         1'b0);
        {m_hi, m_lo} = 64'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("postrst_hilo", {ifc.hi, ifc.lo}, 64'h0);
        send(OP_MULT, 32'h5, 32'h7, 1'b1, 64'h00000000_00000023, "mult_5x7", w, t0);
        repeat (6) @(negedge clk);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit operands and 64-bit product.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-006 req_op  input  2  operation: 00 MULT (signed), 01 MULTU (unsigned), 10 MTHI, 11 MTLO.
REQ-007 req_a  input  32  multiplicand, or write data for MTHI/MTLO.
REQ-008 req_b  input  32  multiplier; ignored for MTHI/MTLO.
REQ-009 mul_a  output  32  registered operand to the downstream signed multiplier.
REQ-010 mul_b  output  32  registered operand to the downstream signed multiplier.
REQ-011 mul_c  input  64  signed product, registered by the multiplier one edge after it samples mul_a/mul_b.
REQ-012 hi  output  32  HI register.
REQ-013 lo  output  32  LO register.
REQ-014 busy  output  1  multiply in flight.
REQ-015 done  output  1  one-cycle pulse in the cycle after HI/LO capture a product.
REQ-016 rd_req  input  1  consumer wants to read HI/LO.
REQ-017 rd_stall  output  1  combinational, equals rd_req && busy.

Function
REQ-018 The FSM SHALL have three states: IDLE, MUL, CAP. req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE, accepted MULT or MULTU at edge T: latch req_a and req_b into mul_a and mul_b, latch the op flag, and go to MUL.
REQ-020 MUL to CAP at edge T+1, unconditionally; the multiplier samples mul_a/mul_b on this edge.
REQ-021 CAP to IDLE at edge T+2: {hi,lo} <= corrected mul_c, and done is 1 for the following cycle.
REQ-022 busy SHALL be 1 in MUL and CAP, and 0 in IDLE.
REQ-023 mul_a and mul_b SHALL hold their values from T until the next accepted multiply.
REQ-024 MULT correction: none; {hi,lo} = mul_c.
REQ-025 MULTU correction: {hi,lo} = mul_c + (mul_a[31] ? mul_b<<32 : 0) + (mul_b[31] ? mul_a<<32 : 0), computed modulo 2^64.
REQ-026 Accepted MTHI at edge T: hi <= req_a and lo is unchanged. Accepted MTLO: lo <= req_a and hi is unchanged. Both complete in one cycle, stay in IDLE, assert no busy and no done.
REQ-027 Requests arriving during MUL or CAP SHALL stall, because req_ready is 0; req_* SHALL be resampled when the FSM returns to IDLE.
REQ-028 Back-to-back operation: a new request is accepted on the first IDLE cycle, so multiply throughput is one every 3 cycles.
REQ-029 hi and lo SHALL show old values until the capture edge, and never a partial update.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, hi=0, lo=0, mul_a=0, mul_b=0, busy=0, done=0, op flag=0.
REQ-031 Reset during MUL or CAP SHALL discard the in-flight product; no capture and no done pulse after release.
REQ-032 On the first edge after rst_n rises, a request SHALL be acceptable.

Configuration
REQ-033 Macro MUL_UNSIGNED_EN:
- Defined: MULTU applies the REQ-025 correction.
- Undefined: the correction logic is omitted and MULTU is executed exactly as MULT (signed result).

Verification
REQ-034 MULT a=3, b=FFFFFFFE accepted at T -> at T+2 hi=FFFFFFFF, lo=FFFFFFFA; done=1 in the following cycle; busy=1 for 2 cycles.
REQ-035 MULTU a=FFFFFFFF, b=00000002 -> with MUL_UNSIGNED_EN: hi=00000001, lo=FFFFFFFE; without it: hi=FFFFFFFF, lo=FFFFFFFE.
REQ-036 MULT a=b=80000000 -> hi=40000000, lo=00000000.
REQ-037 MTHI 12345678 held valid during a MULT in flight -> req_ready=0 until IDLE; the product is captured first, then hi=12345678 while lo keeps the product LO; rd_req during busy gives rd_stall=1.
REQ-038 rst_n pulsed low during MUL -> hi=lo=0 immediately, no done pulse afterwards, and a fresh MULT 5x7 then gives lo=00000023, hi=0.
